// File: rtl/mem_access_ctrl.sv
// Data-memory access controller at the EX/MEM boundary: one SRAM-like bus transaction
// per load/store, EX stall while it is outstanding, aligned/extended load return.
module mem_access_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic        MemReqE,
  input  logic        MemWriteE,
  input  logic [1:0]  MemSizeE,
  input  logic        MemSignE,
  input  logic        FlushE,
  input  logic [31:0] ALUOutE,
  input  logic [31:0] WriteDataE,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        MemStallE,
  output logic [31:0] ReadDataM,
  output logic        DoneM,
  output logic        AdelE,
  output logic        AdesE,
  output logic [31:0] BadVAddrE
);

  localparam int          DATALENGTH = 32;
  localparam logic [DATALENGTH-1:0] ZEROWORD = '0;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  logic [1:0]  state;
  logic        memSign;
  logic        kill;
  logic        misaligned;
  logic        accept;
  logic        complete;
  logic        killNow;
  logic [1:0]  sizeNorm;
  logic [31:0] wdataRep;
  logic [7:0]  loadByte;
  logic [15:0] loadHalf;
  logic [31:0] loadExt;

  assign sizeNorm   = (MemSizeE == 2'b11) ? 2'b10 : MemSizeE;
  assign misaligned = ((MemSizeE == 2'b01) & ALUOutE[0]) |
                      (MemSizeE[1] & (ALUOutE[1:0] != 2'b00));

  assign AdelE     = MemReqE & ~MemWriteE & misaligned & ~FlushE;
  assign AdesE     = MemReqE &  MemWriteE & misaligned & ~FlushE;
  assign BadVAddrE = ALUOutE;

  assign accept   = (state == IDLE) & MemReqE & ~FlushE & ~misaligned;
  assign complete = ((state == REQ) & data_addr_ok & data_data_ok) |
                    ((state == WAIT) & data_data_ok);
  // A flush arriving in the completion cycle itself must also squash the retire.
  assign killNow  = kill | FlushE;

  assign MemStallE = accept | (((state == REQ) | (state == WAIT)) & ~complete);

  always_comb begin
    wdataRep = WriteDataE;
    case (sizeNorm)
      2'b00:   wdataRep = {4{WriteDataE[7:0]}};
      2'b01:   wdataRep = {2{WriteDataE[15:0]}};
      default: wdataRep = WriteDataE;
    endcase
  end

  // Lane selection uses the captured address/size, not the live EX fields.
  always_comb begin
    loadByte = data_rdata[7:0];
    case (data_addr[1:0])
      2'b00:   loadByte = data_rdata[7:0];
      2'b01:   loadByte = data_rdata[15:8];
      2'b10:   loadByte = data_rdata[23:16];
      default: loadByte = data_rdata[31:24];
    endcase
    loadHalf = data_addr[1] ? data_rdata[31:16] : data_rdata[15:0];
    case (data_size)
      2'b00:   loadExt = {{24{memSign & loadByte[7]}}, loadByte};
      2'b01:   loadExt = {{16{memSign & loadHalf[15]}}, loadHalf};
      default: loadExt = data_rdata;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      data_req   <= 1'b0;
      data_wr    <= 1'b0;
      data_size  <= 2'b00;
      data_addr  <= ZEROWORD;
      data_wdata <= ZEROWORD;
      memSign    <= 1'b0;
      kill       <= 1'b0;
      DoneM      <= 1'b0;
      ReadDataM  <= ZEROWORD;
    end else begin
      DoneM <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state      <= REQ;
            data_req   <= 1'b1;
            data_wr    <= MemWriteE;
            data_size  <= sizeNorm;
            memSign    <= MemSignE;
            data_addr  <= ALUOutE;
            data_wdata <= wdataRep;
          end
        end
        REQ: begin
          if (FlushE) kill <= 1'b1;
          if (data_addr_ok) begin
            data_req <= 1'b0;
            state    <= data_data_ok ? IDLE : WAIT;
          end
        end
        WAIT: begin
          if (FlushE) kill <= 1'b1;
          if (data_data_ok) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // The bus cannot cancel, so a killed access still drains but never retires.
      if (complete) begin
        kill  <= 1'b0;
        DoneM <= ~killNow;
        if (~killNow & ~data_wr) ReadDataM <= loadExt;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: expected retire data is queued when an access
// is driven and compared when DoneM pulses; bus responses come from the stimulus task.
module tb_mem_access_ctrl;

  logic        clock;
  logic        reset;
  logic        MemReqE;
  logic        MemWriteE;
  logic [1:0]  MemSizeE;
  logic        MemSignE;
  logic        FlushE;
  logic [31:0] ALUOutE;
  logic [31:0] WriteDataE;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        MemStallE;
  logic [31:0] ReadDataM;
  logic        DoneM;
  logic        AdelE;
  logic        AdesE;
  logic [31:0] BadVAddrE;

  int          vectorCount;
  int          missCount;
  logic [31:0] modelRead;
  logic [31:0] scoreboard[$];

  mem_access_ctrl dut (
    .clock(clock), .reset(reset),
    .MemReqE(MemReqE), .MemWriteE(MemWriteE), .MemSizeE(MemSizeE),
    .MemSignE(MemSignE), .FlushE(FlushE), .ALUOutE(ALUOutE), .WriteDataE(WriteDataE),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .MemStallE(MemStallE), .ReadDataM(ReadDataM), .DoneM(DoneM),
    .AdelE(AdelE), .AdesE(AdesE), .BadVAddrE(BadVAddrE)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [31:0] expLoad(input logic [1:0] size, input logic sign,
                                          input logic [31:0] addr, input logic [31:0] rdata);
    logic [31:0] sh;
    if (size == 2'b00) begin
      sh = rdata >> (8 * addr[1:0]);
      return (sh & 32'h0000_00FF) | ((sign && sh[7]) ? 32'hFFFF_FF00 : 32'h0);
    end else if (size == 2'b01) begin
      sh = rdata >> (16 * addr[1]);
      return (sh & 32'h0000_FFFF) | ((sign && sh[15]) ? 32'hFFFF_0000 : 32'h0);
    end
    return rdata;
  endfunction

  function automatic logic [31:0] expWdata(input logic [1:0] size, input logic [31:0] w);
    if (size == 2'b00) return {24'h0, w[7:0]} * 32'h0101_0101;
    if (size == 2'b01) return {16'h0, w[15:0]} * 32'h0001_0001;
    return w;
  endfunction

  // Retire monitor: every DoneM pulse must match the oldest queued expectation.
  always @(negedge clock) begin
    if (!reset && DoneM) begin
      if (scoreboard.size() == 0) checkOutput("sbUnexpectedDone", {31'h0, DoneM}, 32'h0);
      else checkOutput("sbReadData", ReadDataM, scoreboard.pop_front());
    end
  end

  // Entered and left just after a rising edge; addrDelay/dataDelay count extra bus wait cycles.
  task automatic applyStimulus(input logic wr, input logic [1:0] size, input logic sign,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] rdata, input int addrDelay,
                               input int dataDelay, input logic flushInWait);
    logic        killed;
    logic [31:0] expW;
    logic [1:0]  expSize;
    killed  = flushInWait && (dataDelay > 1);
    expW    = expWdata(size, wdata);
    expSize = (size == 2'b11) ? 2'b10 : size;
    if (!killed && !wr) modelRead = expLoad(size, sign, addr, rdata);
    if (!killed) scoreboard.push_back(modelRead);

    MemReqE = 1'b1; MemWriteE = wr; MemSizeE = size; MemSignE = sign;
    ALUOutE = addr; WriteDataE = wdata; FlushE = 1'b0;
    @(negedge clock);
    checkOutput("acceptStall", {31'h0, MemStallE}, 32'h1);
    checkOutput("idleReq", {31'h0, data_req}, 32'h0);
    @(posedge clock); #1;

    for (int k = 0; k <= addrDelay; k++) begin
      if (k == addrDelay) begin
        data_addr_ok = 1'b1;
        if (dataDelay == 0) begin data_data_ok = 1'b1; data_rdata = rdata; end
      end
      @(negedge clock);
      checkOutput("reqValid", {31'h0, data_req}, 32'h1);
      checkOutput("reqWr", {31'h0, data_wr}, {31'h0, wr});
      checkOutput("reqSize", {30'h0, data_size}, {30'h0, expSize});
      checkOutput("reqAddr", data_addr, addr);
      checkOutput("reqWdata", data_wdata, expW);
      checkOutput("reqStall", {31'h0, MemStallE}, (k == addrDelay && dataDelay == 0) ? 32'h0 : 32'h1);
      @(posedge clock); #1;
      data_addr_ok = 1'b0; data_data_ok = 1'b0;
    end

    for (int j = 1; j <= dataDelay; j++) begin
      FlushE = (killed && j == 1);
      if (j == dataDelay) begin data_data_ok = 1'b1; data_rdata = rdata; end
      @(negedge clock);
      checkOutput("waitReq", {31'h0, data_req}, 32'h0);
      checkOutput("waitStall", {31'h0, MemStallE}, (j == dataDelay) ? 32'h0 : 32'h1);
      @(posedge clock); #1;
      data_data_ok = 1'b0; FlushE = 1'b0;
    end

    MemReqE = 1'b0;
    data_rdata = $urandom;
    @(negedge clock);
    checkOutput("doneM", {31'h0, DoneM}, {31'h0, !killed});
    checkOutput("readData", ReadDataM, modelRead);
    @(posedge clock); #1;
  endtask

  initial begin
    vectorCount = 0; missCount = 0; modelRead = 32'h0;
    reset = 1'b1; MemReqE = 1'b0; MemWriteE = 1'b0; MemSizeE = 2'b00; MemSignE = 1'b0;
    FlushE = 1'b0; ALUOutE = 32'h0; WriteDataE = 32'h0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("rstReq", {31'h0, data_req}, 32'h0);
    checkOutput("rstWr", {31'h0, data_wr}, 32'h0);
    checkOutput("rstDone", {31'h0, DoneM}, 32'h0);
    checkOutput("rstSize", {30'h0, data_size}, 32'h0);
    checkOutput("rstAddr", data_addr, 32'h0);
    checkOutput("rstWdata", data_wdata, 32'h0);
    checkOutput("rstRead", ReadDataM, 32'h0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;

    applyStimulus(1'b1, 2'b10, 1'b0, 32'h1000_0004, 32'hDEAD_BEEF, 32'h0, 0, 0, 1'b0);
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h1000_0003, 32'h1234_56A5, 32'h0, 0, 0, 1'b0);
    applyStimulus(1'b0, 2'b00, 1'b1, 32'h1000_0002, 32'h0, 32'h1180_7F22, 0, 0, 1'b0);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h1000_0002, 32'h0, 32'h1180_7F22, 0, 0, 1'b0);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h1000_0008, 32'h0, 32'hCAFE_F00D, 3, 2, 1'b0);
    applyStimulus(1'b0, 2'b01, 1'b1, 32'h1000_0006, 32'h0, 32'h8001_7FFF, 1, 0, 1'b0);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h1000_0004, 32'h0, 32'h8001_FFFE, 0, 1, 1'b0);
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h1000_0002, 32'h0000_BEEF, 32'h0, 0, 0, 1'b0);

    // Misaligned accesses: exception only, no bus traffic, no stall
    MemReqE = 1'b1; MemWriteE = 1'b0; MemSizeE = 2'b01; MemSignE = 1'b1; ALUOutE = 32'h1000_0001;
    @(negedge clock);
    checkOutput("lhAdel", {31'h0, AdelE}, 32'h1);
    checkOutput("lhAdes", {31'h0, AdesE}, 32'h0);
    checkOutput("lhBadVAddr", BadVAddrE, 32'h1000_0001);
    checkOutput("lhStall", {31'h0, MemStallE}, 32'h0);
    @(posedge clock); #1;
    checkOutput("lhNoReq", {31'h0, data_req}, 32'h0);
    MemWriteE = 1'b1; MemSizeE = 2'b10; ALUOutE = 32'h1000_0002;
    @(negedge clock);
    checkOutput("swAdes", {31'h0, AdesE}, 32'h1);
    checkOutput("swAdel", {31'h0, AdelE}, 32'h0);
    checkOutput("swBadVAddr", BadVAddrE, 32'h1000_0002);
    checkOutput("swStall", {31'h0, MemStallE}, 32'h0);
    @(posedge clock); #1;
    checkOutput("swNoReq", {31'h0, data_req}, 32'h0);
    MemReqE = 1'b0;

    // Flush while waiting for data: access drains silently, then a normal load follows
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h1000_000C, 32'h0, 32'h5555_5555, 0, 3, 1'b1);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h1000_0001, 32'h0, 32'h0000_9900, 0, 0, 1'b0);

    // Reset while a request is on the bus
    MemReqE = 1'b1; MemWriteE = 1'b0; MemSizeE = 2'b10; MemSignE = 1'b0; ALUOutE = 32'h1000_0010;
    @(posedge clock); #1;
    checkOutput("preRstReq", {31'h0, data_req}, 32'h1);
    reset = 1'b1; MemReqE = 1'b0;
    #1;
    checkOutput("midRstReq", {31'h0, data_req}, 32'h0);
    checkOutput("midRstStall", {31'h0, MemStallE}, 32'h0);
    checkOutput("midRstRead", ReadDataM, 32'h0);
    @(posedge clock); #1;
    reset = 1'b0; modelRead = 32'h0;
    data_addr_ok = 1'b1; data_data_ok = 1'b1;
    repeat (2) begin
      @(negedge clock);
      checkOutput("postRstReq", {31'h0, data_req}, 32'h0);
      checkOutput("postRstDone", {31'h0, DoneM}, 32'h0);
      @(posedge clock); #1;
    end
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
    checkOutput("sbDrained", scoreboard.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
